// File: rtl/pll_reset_sequencer.sv
// PLL reset / lock qualification sequencer: pulses pll_rst, waits for stable lock, releases core reset.
// Optional lock-loss event counter built only when PLL_LOCK_LOSS_COUNT_EN is defined.
module pll_reset_sequencer #(
    parameter int RST_CYCLES      = 32,
    parameter int LOCK_TIMEOUT    = 65536,
    parameter int STABLE_CYCLES   = 1024,
    parameter int CORE_RST_CYCLES = 16,
    parameter int MAX_RETRY       = 3,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       req_reset,
    output logic       pll_rst,
    output logic       sys_reset_n,
    output logic       ready,
    output logic       fault,
    output logic [3:0] retry_cnt,
    output logic [7:0] lock_loss_cnt,
    output logic [2:0] dbg_state
);

    localparam logic [2:0] S_PLLRST   = 3'd0;
    localparam logic [2:0] S_WAITLOCK = 3'd1;
    localparam logic [2:0] S_STABLE   = 3'd2;
    localparam logic [2:0] S_RUN      = 3'd3;
    localparam logic [2:0] S_CORERST  = 3'd4;
    localparam logic [2:0] S_FAULT    = 3'd5;

    localparam logic [CNT_W-1:0] CNT_ZERO    = '0;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CORE_LAST   = CNT_W'(CORE_RST_CYCLES - 1);
    localparam logic [3:0]       RETRY_MAX   = 4'(MAX_RETRY);

    logic [1:0]       r_sync;
    logic             w_lock_s;
    logic             r_req_d;
    logic             w_req_rise;
    logic [2:0]       r_state;
    logic [2:0]       w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_next_cnt;
    logic [3:0]       r_retry;
    logic [3:0]       w_next_retry;
    logic [3:0]       w_retry_inc;
    logic             r_pll_rst;
    logic             r_sys_reset_n;
    logic             r_ready;
    logic             r_fault;

    assign w_lock_s    = r_sync[1];
    assign w_req_rise  = req_reset & ~r_req_d;
    assign w_retry_inc = r_retry + 4'd1;

    // Edge detector resets high so a request held through reset is not seen as an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= 2'b00;
            r_req_d <= 1'b1;
        end else begin
            r_sync  <= {r_sync[0], pll_locked};
            r_req_d <= req_reset;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_next_retry = r_retry;
        case (r_state)
            S_PLLRST: begin
                if (r_cnt == RST_LAST) begin
                    w_next_state = S_WAITLOCK;
                    w_next_cnt   = CNT_ZERO;
                end else begin
                    w_next_cnt = r_cnt + CNT_ONE;
                end
            end
            S_WAITLOCK: begin
                // Lock takes priority over a timeout on the same clock.
                if (w_lock_s) begin
                    w_next_state = S_STABLE;
                    w_next_cnt   = CNT_ZERO;
                end else if (r_cnt == TO_LAST) begin
                    w_next_retry = w_retry_inc;
                    w_next_cnt   = CNT_ZERO;
                    w_next_state = (w_retry_inc == RETRY_MAX) ? S_FAULT : S_PLLRST;
                end else begin
                    w_next_cnt = r_cnt + CNT_ONE;
                end
            end
            S_STABLE: begin
                if (!w_lock_s) begin
                    w_next_state = S_WAITLOCK;
                    w_next_cnt   = CNT_ZERO;
                end else if (r_cnt == STABLE_LAST) begin
                    w_next_state = S_RUN;
                    w_next_cnt   = CNT_ZERO;
                    w_next_retry = 4'd0;
                end else begin
                    w_next_cnt = r_cnt + CNT_ONE;
                end
            end
            S_RUN: begin
                if (!w_lock_s) begin
                    w_next_state = S_PLLRST;
                    w_next_cnt   = CNT_ZERO;
                end else if (w_req_rise) begin
                    w_next_state = S_CORERST;
                    w_next_cnt   = CNT_ZERO;
                end
            end
            S_CORERST: begin
                if (!w_lock_s) begin
                    w_next_state = S_PLLRST;
                    w_next_cnt   = CNT_ZERO;
                end else if (req_reset) begin
                    w_next_cnt = CNT_ZERO;
                end else if (r_cnt == CORE_LAST) begin
                    w_next_state = S_RUN;
                    w_next_cnt   = CNT_ZERO;
                end else begin
                    w_next_cnt = r_cnt + CNT_ONE;
                end
            end
            S_FAULT: begin
                if (w_req_rise) begin
                    w_next_state = S_PLLRST;
                    w_next_cnt   = CNT_ZERO;
                    w_next_retry = 4'd0;
                end
            end
            default: begin
                w_next_state = S_PLLRST;
                w_next_cnt   = CNT_ZERO;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register together with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_PLLRST;
            r_cnt         <= CNT_ZERO;
            r_retry       <= 4'd0;
            r_pll_rst     <= 1'b1;
            r_sys_reset_n <= 1'b0;
            r_ready       <= 1'b0;
            r_fault       <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_cnt         <= w_next_cnt;
            r_retry       <= w_next_retry;
            r_pll_rst     <= (w_next_state == S_PLLRST);
            r_sys_reset_n <= (w_next_state == S_RUN);
            r_ready       <= (w_next_state == S_RUN);
            r_fault       <= (w_next_state == S_FAULT);
        end
    end

`ifdef PLL_LOCK_LOSS_COUNT_EN
    logic       w_lock_lost;
    logic [7:0] r_lock_loss;

    assign w_lock_lost = ((r_state == S_RUN) || (r_state == S_CORERST)) && !w_lock_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_loss <= 8'd0;
        end else if (w_lock_lost && (r_lock_loss != 8'hFF)) begin
            r_lock_loss <= r_lock_loss + 8'd1;
        end
    end

    assign lock_loss_cnt = r_lock_loss;
`else
    assign lock_loss_cnt = 8'd0;
`endif

    assign pll_rst     = r_pll_rst;
    assign sys_reset_n = r_sys_reset_n;
    assign ready       = r_ready;
    assign fault       = r_fault;
    assign retry_cnt   = r_retry;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: per-cycle expected output vectors queued and compared on each negedge.
module tb_pll_reset_sequencer;

    logic       clk;
    logic       rst_n;
    logic       pll_locked;
    logic       req_reset;
    logic       pll_rst;
    logic       sys_reset_n;
    logic       ready;
    logic       fault;
    logic [3:0] retry_cnt;
    logic [7:0] lock_loss_cnt;
    logic [2:0] dbg_state;
    logic [15:0] w_obs;

    logic [15:0] exp_q[$];
    int n_cmp;
    int n_err;

`ifdef PLL_LOCK_LOSS_COUNT_EN
    localparam bit LLC_EN = 1'b1;
`else
    localparam bit LLC_EN = 1'b0;
`endif

    pll_reset_sequencer #(
        .RST_CYCLES     (4),
        .LOCK_TIMEOUT   (16),
        .STABLE_CYCLES  (8),
        .CORE_RST_CYCLES(3),
        .MAX_RETRY      (2),
        .CNT_W          (20)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pll_locked   (pll_locked),
        .req_reset    (req_reset),
        .pll_rst      (pll_rst),
        .sys_reset_n  (sys_reset_n),
        .ready        (ready),
        .fault        (fault),
        .retry_cnt    (retry_cnt),
        .lock_loss_cnt(lock_loss_cnt),
        .dbg_state    (dbg_state)
    );

    assign w_obs = {pll_rst, sys_reset_n, ready, fault, retry_cnt, lock_loss_cnt};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected vector layout: {pll_rst, sys_reset_n, ready, fault, retry_cnt, lock_loss_cnt}
    function automatic logic [15:0] vec(input logic pr, input logic sn, input logic rd,
                                        input logic ft, input logic [3:0] rc, input int llc);
        logic [7:0] l;
        l = LLC_EN ? 8'(llc) : 8'd0;
        return {pr, sn, rd, ft, rc, l};
    endfunction

    task automatic apply_reset();
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        req_reset  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Sample k is taken on the negedge after k clock edges since the task began.
    task automatic test_reset();
        logic [15:0] exp;
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        req_reset  = 1'b1;
        repeat (3) @(negedge clk);
        exp = vec(1, 0, 0, 0, 4'd0, 0);
        n_cmp++;
        if (w_obs !== exp) begin
            n_err++;
            $display("FAIL reset_values got=%h exp=%h", w_obs, exp);
        end
        rst_n = 1'b1;
        // lock raised before edge 6: 2 sync edges + 1 to STABLE + 8 stable -> RUN on edge 16
        for (int k = 0; k <= 18; k++) exp_q.push_back(vec(k <= 3, k >= 16, k >= 16, 0, 4'd0, 0));
        for (int k = 0; k <= 18; k++) begin
            exp = exp_q.pop_front();
            n_cmp++;
            if (w_obs !== exp) begin
                n_err++;
                $display("FAIL lock_bringup k=%0d got=%h exp=%h", k, w_obs, exp);
            end
            if (k == 5) pll_locked = 1'b1;
            @(negedge clk);
        end
        req_reset = 1'b0;
    endtask

    task automatic test_lock_timeout_fault();
        logic [15:0] exp;
        logic [3:0]  rc;
        apply_reset();
        for (int k = 0; k <= 50; k++) begin
            rc = (k < 20) ? 4'd0 : (k < 40) ? 4'd1 : (k < 45) ? 4'd2 : 4'd0;
            exp_q.push_back(vec((k <= 3) || (k >= 20 && k <= 23) || (k >= 45 && k <= 48),
                                0, 0, (k >= 40 && k <= 44), rc, 0));
        end
        for (int k = 0; k <= 50; k++) begin
            exp = exp_q.pop_front();
            n_cmp++;
            if (w_obs !== exp) begin
                n_err++;
                $display("FAIL timeout_fault k=%0d got=%h exp=%h", k, w_obs, exp);
            end
            if (k == 44) req_reset = 1'b1;
            if (k == 45) req_reset = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_stable_glitch();
        logic [15:0] exp;
        apply_reset();
        pll_locked = 1'b1;
        // STABLE from edge 5, glitch forces WAITLOCK at 10, STABLE again at 13, RUN at 21
        for (int k = 0; k <= 24; k++) exp_q.push_back(vec(k <= 3, k >= 21, k >= 21, 0, 4'd0, 0));
        for (int k = 0; k <= 24; k++) begin
            exp = exp_q.pop_front();
            n_cmp++;
            if (w_obs !== exp) begin
                n_err++;
                $display("FAIL stable_glitch k=%0d got=%h exp=%h", k, w_obs, exp);
            end
            if (k == 7)  pll_locked = 1'b0;
            if (k == 10) pll_locked = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_lock_loss();
        logic [15:0] exp;
        for (int k = 0; k <= 20; k++)
            exp_q.push_back(vec(k >= 3 && k <= 6, k <= 2 || k >= 19, k <= 2 || k >= 19, 0, 4'd0,
                                (k >= 3) ? 1 : 0));
        for (int k = 0; k <= 20; k++) begin
            exp = exp_q.pop_front();
            n_cmp++;
            if (w_obs !== exp) begin
                n_err++;
                $display("FAIL lock_loss k=%0d got=%h exp=%h", k, w_obs, exp);
            end
            if (k == 0) pll_locked = 1'b0;
            if (k == 8) pll_locked = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp;
        logic        run;
        for (int k = 0; k <= 38; k++) begin
            run = (k == 0) || (k >= 13 && k <= 15) || (k >= 37);
            exp_q.push_back(vec(k >= 21 && k <= 24, run, run, 0, 4'd0, (k >= 21) ? 2 : 1));
        end
        for (int k = 0; k <= 38; k++) begin
            exp = exp_q.pop_front();
            n_cmp++;
            if (w_obs !== exp) begin
                n_err++;
                $display("FAIL core_reset_req k=%0d got=%h exp=%h", k, w_obs, exp);
            end
            if (k == 0)  req_reset  = 1'b1;
            if (k == 10) req_reset  = 1'b0;
            if (k == 15) req_reset  = 1'b1;
            if (k == 18) pll_locked = 1'b0;
            if (k == 25) req_reset  = 1'b0;
            if (k == 26) pll_locked = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_async_reset();
        logic [15:0] exp;
        for (int k = 0; k <= 9; k++)
            exp_q.push_back(vec(k >= 3 && k <= 6, k <= 2, k <= 2, 0, 4'd0, (k >= 3) ? 3 : 2));
        for (int k = 0; k <= 9; k++) begin
            exp = exp_q.pop_front();
            n_cmp++;
            if (w_obs !== exp) begin
                n_err++;
                $display("FAIL pre_abort k=%0d got=%h exp=%h", k, w_obs, exp);
            end
            if (k == 0) pll_locked = 1'b0;
            @(negedge clk);
        end
        rst_n = 1'b0;
        #2;
        exp = vec(1, 0, 0, 0, 4'd0, 0);
        n_cmp++;
        if (w_obs !== exp) begin
            n_err++;
            $display("FAIL async_abort got=%h exp=%h", w_obs, exp);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k <= 7; k++) exp_q.push_back(vec(k <= 3, 0, 0, 0, 4'd0, 0));
        for (int k = 0; k <= 7; k++) begin
            exp = exp_q.pop_front();
            n_cmp++;
            if (w_obs !== exp) begin
                n_err++;
                $display("FAIL restart_pulse k=%0d got=%h exp=%h", k, w_obs, exp);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        req_reset  = 1'b0;
        test_reset();
        test_lock_timeout_fault();
        test_stable_glitch();
        test_lock_loss();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
